// File: rtl/trace_arb_pkg.sv
// Shared types and sizing helpers for the trace arbiter.
// Optional statistics counters are enabled with TRACE_ARB_STATS_EN.
package trace_arb_pkg;

  localparam int unsigned DEF_DW   = 8;
  localparam int unsigned DEF_CNTW = 16;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Source-index width; a single requester still needs one bit.
  function automatic int unsigned src_width(input int unsigned n);
    return (n > 1) ? 32'($clog2(n)) : 32'd1;
  endfunction

endpackage

// File: rtl/trace_arbiter_if.sv
// Requester bundle plus the single valid/ready sink port of the trace arbiter.
interface trace_arbiter_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DW   = trace_arb_pkg::DEF_DW
) ();
  import trace_arb_pkg::*;

  localparam int unsigned SRCW = src_width(NREQ);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_x;
  logic [NREQ*DW-1:0] req_y;
  logic [NREQ-1:0]    req_ready;
  logic               out_valid;
  logic [DW-1:0]      out_x;
  logic [DW-1:0]      out_y;
  logic [SRCW-1:0]    out_src;
  logic               out_ready;

  // Environment side: requesters and sink.
  modport master (
    output req_valid, req_x, req_y, out_ready,
    input  req_ready, out_valid, out_x, out_y, out_src
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_x, req_y, out_ready,
    output req_ready, out_valid, out_x, out_y, out_src
  );

endinterface

// File: rtl/trace_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick
  import trace_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned SRCW = src_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [SRCW-1:0] ptr,
  output logic [NREQ-1:0] grant,
  output logic [SRCW-1:0] idx,
  output logic            any
);

  logic [SRCW-1:0] cand;
  logic            found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = SRCW'((32'(ptr) + k) % NREQ);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/trace_arbiter.sv
// Round-robin arbiter sharing one registered valid/ready trace sink among NREQ requesters.
// Define TRACE_ARB_STATS_EN to add per-requester grant counters and a stall counter.
module trace_arbiter
  import trace_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DW   = DEF_DW,
  parameter int unsigned CNTW = DEF_CNTW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  trace_arbiter_if.slave       bus
`ifdef TRACE_ARB_STATS_EN
  ,
  output logic [NREQ*CNTW-1:0] grant_cnt,
  output logic [CNTW-1:0]      stall_cnt
`endif
);

  localparam int unsigned SRCW = src_width(NREQ);

  state_e          state_q, state_d;
  logic            out_valid_q, out_valid_d;
  logic [DW-1:0]   out_x_q, out_x_d;
  logic [DW-1:0]   out_y_q, out_y_d;
  logic [SRCW-1:0] out_src_q, out_src_d;
  logic [SRCW-1:0] ptr_q, ptr_d;

  logic [NREQ-1:0] pick_grant;
  logic [SRCW-1:0] pick_idx;
  logic            pick_any;
  logic            load_c;
  logic [NREQ-1:0] xfer_c;

  rr_pick #(
    .NREQ (NREQ),
    .SRCW (SRCW)
  ) u_pick (
    .req   (bus.req_valid),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Output register is free when empty or being drained this cycle.
  assign load_c = (state_q == IDLE) | (out_valid_q & bus.out_ready);
  assign xfer_c = (load_c && rst_n) ? pick_grant : '0;
  assign bus.req_ready = xfer_c;

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_x_d     = out_x_q;
    out_y_d     = out_y_q;
    out_src_d   = out_src_q;
    ptr_d       = ptr_q;
    if (load_c) begin
      if (pick_any) begin
        state_d     = BUSY;
        out_valid_d = 1'b1;
        out_x_d     = bus.req_x[pick_idx*DW +: DW];
        out_y_d     = bus.req_y[pick_idx*DW +: DW];
        out_src_d   = pick_idx;
        ptr_d       = (32'(pick_idx) == NREQ - 1) ? '0 : SRCW'(32'(pick_idx) + 32'd1);
      end else begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      out_src_q   <= '0;
      ptr_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_x_q     <= out_x_d;
      out_y_q     <= out_y_d;
      out_src_q   <= out_src_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_x     = out_x_q;
  assign bus.out_y     = out_y_q;
  assign bus.out_src   = out_src_q;

`ifdef TRACE_ARB_STATS_EN
  localparam logic [CNTW-1:0] CNT_MAX = '1;

  logic [NREQ*CNTW-1:0] grant_cnt_q, grant_cnt_d;
  logic [CNTW-1:0]      stall_cnt_q, stall_cnt_d;
  logic [CNTW-1:0]      gc;

  // Saturating counters: transfers per requester and back-pressured cycles.
  always_comb begin
    grant_cnt_d = grant_cnt_q;
    gc          = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      gc = grant_cnt_q[i*CNTW +: CNTW];
      if (xfer_c[i] && (gc != CNT_MAX)) begin
        grant_cnt_d[i*CNTW +: CNTW] = gc + CNTW'(1);
      end
    end
    stall_cnt_d = stall_cnt_q;
    if (out_valid_q && !bus.out_ready && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      grant_cnt_q <= grant_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign grant_cnt = grant_cnt_q;
  assign stall_cnt = stall_cnt_q;
`else
  logic unused_cntw;
  assign unused_cntw = (CNTW == 0);
`endif

endmodule

// File: tb/tb_trace_arbiter.sv
// Randomized and directed bench for trace_arbiter against a queue-free behavioural model.
module tb_trace_arbiter;
  import trace_arb_pkg::*;

  localparam int unsigned NREQ = 4;
  localparam int unsigned DW   = 8;
  localparam int unsigned CNTW = 3;
  localparam int unsigned SRCW = src_width(NREQ);
  localparam int unsigned XW   = NREQ * DW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  trace_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

`ifdef TRACE_ARB_STATS_EN
  logic [NREQ*CNTW-1:0] grant_cnt;
  logic [CNTW-1:0]      stall_cnt;
`endif

  trace_arbiter #(.NREQ(NREQ), .DW(DW), .CNTW(CNTW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
`ifdef TRACE_ARB_STATS_EN
    ,
    .grant_cnt (grant_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: what the sink must currently see, and the scan start.
  bit            m_busy;
  logic [DW-1:0] m_x, m_y;
  int            m_src, m_ptr;
  int            m_gcnt [NREQ];
  int            m_stall;
  logic [NREQ-1:0] last_rdy;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [XW-1:0] put(input int idx, input logic [DW-1:0] val);
    return XW'(val) << (idx * DW);
  endfunction

  task automatic model_reset();
    m_busy = 1'b0; m_x = '0; m_y = '0; m_src = 0; m_ptr = 0; m_stall = 0;
    for (int i = 0; i < NREQ; i++) m_gcnt[i] = 0;
  endtask

  // Called at a falling edge: drive, compare, let one rising edge pass, return at next falling edge.
  task automatic step(input logic [NREQ-1:0] v, input logic [XW-1:0] xs, input logic [XW-1:0] ys,
                      input logic ordy);
    int win;
    int sat;
    int j;
    bit load;
    logic [NREQ-1:0] exp_rdy, sh;
    bus.req_valid = v;
    bus.req_x     = xs;
    bus.req_y     = ys;
    bus.out_ready = ordy;
    #1;
    load = !m_busy || ordy;
    win  = -1;
    if (load && rst_n) begin
      for (int k = 0; k < NREQ; k++) begin
        j  = (m_ptr + k) % NREQ;
        sh = v >> j;
        if (win < 0 && sh[0]) win = j;
      end
    end
    exp_rdy  = (win >= 0) ? (NREQ'(1) << win) : '0;
    last_rdy = bus.req_ready;
    check("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
    check("out_valid", 64'(bus.out_valid), 64'(m_busy));
    if (m_busy || !rst_n) begin
      check("out_x",   64'(bus.out_x),   64'(m_x));
      check("out_y",   64'(bus.out_y),   64'(m_y));
      check("out_src", 64'(bus.out_src), 64'(m_src));
    end
`ifdef TRACE_ARB_STATS_EN
    for (int i = 0; i < NREQ; i++)
      check("grant_cnt", 64'(CNTW'(grant_cnt >> (i * CNTW))), 64'(m_gcnt[i]));
    check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
`endif
    @(posedge clk);
    if (rst_n) begin
      sat = (1 << CNTW) - 1;
      if (m_busy && !ordy && m_stall < sat) m_stall++;
      if (load) begin
        if (win >= 0) begin
          m_busy = 1'b1;
          m_x    = DW'(xs >> (win * DW));
          m_y    = DW'(ys >> (win * DW));
          m_src  = win;
          m_ptr  = (win + 1) % NREQ;
          if (m_gcnt[win] < sat) m_gcnt[win]++;
        end else begin
          m_busy = 1'b0;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    step('0, '0, '0, 1'b1);
    rst_n = 1'b1;
  endtask

  initial begin
    int seq [6];
    seq = '{0, 1, 2, 3, 0, 1};
    bus.req_valid = '0; bus.req_x = '0; bus.req_y = '0; bus.out_ready = 1'b0;
    model_reset();
    @(negedge clk);
    step('0, '0, '0, 1'b1);
    check("reset_out_valid", 64'(bus.out_valid), 64'd0);
    check("reset_out_src", 64'(bus.out_src), 64'd0);
    rst_n = 1'b1;

    // Single requester, one-cycle latency.
    step(4'b0001, put(0, 8'd5), put(0, 8'd6), 1'b1);
    check("t1_req_ready", 64'(last_rdy), 64'h1);
    check("t1_out_valid", 64'(bus.out_valid), 64'd1);
    check("t1_out_x", 64'(bus.out_x), 64'd5);
    check("t1_out_y", 64'(bus.out_y), 64'd6);
    check("t1_out_src", 64'(bus.out_src), 64'd0);

    // All requesters continuously: strict rotation, no bubble.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(4'hF, XW'($urandom), XW'($urandom), 1'b1);
      check("t2_out_src", 64'(bus.out_src), 64'(seq[i]));
      check("t2_out_valid", 64'(bus.out_valid), 64'd1);
    end

    // Back-pressure hold, then reload in the releasing cycle.
    step(4'b0010, put(1, 8'h11), put(1, 8'h12), 1'b1);
    check("t3_out_x", 64'(bus.out_x), 64'h11);
    for (int i = 0; i < 3; i++) begin
      step(4'b0010, put(1, 8'h22), put(1, 8'h23), 1'b0);
      check("t3_hold_rdy", 64'(last_rdy), 64'h0);
      check("t3_hold_x", 64'(bus.out_x), 64'h11);
      check("t3_hold_src", 64'(bus.out_src), 64'd1);
    end
    step(4'b0010, put(1, 8'h22), put(1, 8'h23), 1'b1);
    check("t3_release_rdy", 64'(last_rdy), 64'h2);
    check("t3_reload_x", 64'(bus.out_x), 64'h22);

    // Wrap: pointer at 3, only req1 valid.
    step(4'b0100, put(2, 8'h33), put(2, 8'h34), 1'b1);
    step(4'b0010, put(1, 8'd7), put(1, 8'd9), 1'b1);
    check("t4_req_ready", 64'(last_rdy), 64'h2);
    check("t4_out_src", 64'(bus.out_src), 64'd1);
    check("t4_out_x", 64'(bus.out_x), 64'd7);
    step(4'hF, XW'($urandom), XW'($urandom), 1'b1);
    check("t4_ptr_is_2", 64'(last_rdy), 64'h4);

    // Asynchronous reset while a pair is held.
    step(4'hF, XW'($urandom), XW'($urandom), 1'b0);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("t5_async_out_valid", 64'(bus.out_valid), 64'd0);
    check("t5_async_req_ready", 64'(bus.req_ready), 64'd0);
    @(negedge clk);
    step(4'hF, XW'($urandom), XW'($urandom), 1'b1);
    rst_n = 1'b1;
    step(4'hF, put(0, 8'h5A), put(0, 8'hA5), 1'b1);
    check("t5_first_rdy", 64'(last_rdy), 64'h1);
    check("t5_first_src", 64'(bus.out_src), 64'd0);
    check("t5_first_x", 64'(bus.out_x), 64'h5A);

`ifdef TRACE_ARB_STATS_EN
    // Saturating counters with a 3-bit width.
    do_reset();
    for (int i = 0; i < 9; i++) step(4'b0100, XW'($urandom), XW'($urandom), 1'b1);
    check("t6_grant_cnt2", 64'(CNTW'(grant_cnt >> (2 * CNTW))), 64'd7);
    for (int i = 0; i < 4; i++) step(4'b0100, XW'($urandom), XW'($urandom), 1'b0);
    check("t6_stall_cnt", 64'(stall_cnt), 64'd4);
`endif

    // Random traffic with occasional resets.
    do_reset();
    for (int n = 0; n < 800; n++) begin
      logic [NREQ-1:0] v;
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        v = ($urandom_range(0, 3) == 0) ? '0 : NREQ'($urandom);
        step(v, XW'($urandom), XW'($urandom), ($urandom_range(0, 3) != 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
